// File: rtl/sample_voice_scheduler.sv
// sample_voice_scheduler
//   Turns 16 bank trigger levels into at most NUM_VOICES playback voices. Once
//   per audio frame it fetches one sample per active voice from a shared
//   single-port ROM, sums them and presents a saturated 16-bit mix.
// Ports
//   clk, rst_n        clock, async active-low reset
//   trig[15:0]        bank request levels (rising edge starts bank b)
//   frame_tick        one-cycle sample-rate pulse
//   rom_req/rom_addr  one-cycle ROM read strobe, address {bank, pos}
//   rom_valid/data    ROM response, L >= 1 cycles after rom_req
//   mix_out/mix_valid saturated mix, one-cycle update strobe
//   voice_active      per-voice busy flags
//   drop_count        saturating count of starts with no free voice
//   overrun           sticky: frame_tick arrived while a frame was running
module sample_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int POS_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           trig,
    input  logic                  frame_tick,
    output logic                  rom_req,
    output logic [4+POS_W-1:0]    rom_addr,
    input  logic                  rom_valid,
    input  logic [15:0]           rom_data,
    output logic [15:0]           mix_out,
    output logic                  mix_valid,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic [7:0]            drop_count,
    output logic                  overrun
);

    localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = 16 + $clog2(NUM_VOICES) + 1;
    localparam logic [VI_W-1:0]         LAST_V   = VI_W'(NUM_VOICES - 1);
    localparam logic [POS_W-1:0]        LAST_POS = '1;
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(-32768);

    typedef enum logic [2:0] {S_IDLE, S_ALLOC, S_FETCH, S_WAIT, S_OUT} state_t;

    state_t                           state;
    logic [3:0]                       scan;
    logic [VI_W-1:0]                  vi;
    logic [15:0]                      trig_q, pend, pend_nxt, edge_set, pend_clr;
    logic [NUM_VOICES-1:0]            active;
    logic [NUM_VOICES-1:0][3:0]       vbank;
    logic [NUM_VOICES-1:0][POS_W-1:0] vpos;
    logic signed [ACC_W-1:0]          acc, rom_ext;
    logic [15:0]                      mix_sat;
    logic                             hit, free;
    logic [VI_W-1:0]                  hit_v, free_v;

    assign voice_active = active;
    assign edge_set     = trig & ~trig_q;
    assign rom_ext      = ACC_W'(signed'(rom_data));

    // The request is decoded straight from the FETCH state so the ROM sees it
    // in the FETCH cycle itself; an active voice then costs exactly L extra
    // cycles per frame. FETCH->WAIT means rom_req can never fire back-to-back.
    assign rom_req  = (state == S_FETCH) && active[vi];
    assign rom_addr = rom_req ? {vbank[vi], vpos[vi]} : '0;

    // Bank being scanned: an existing voice on it (retrigger) or the lowest free one.
    always_comb begin
        hit    = 1'b0;
        hit_v  = '0;
        free   = 1'b0;
        free_v = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active[v] && vbank[v] == scan && !hit) begin
                hit   = 1'b1;
                hit_v = VI_W'(v);
            end
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active[v]) begin
                free   = 1'b1;
                free_v = VI_W'(v);
            end
        end
    end

    // A new edge landing on the bank's own ALLOC slot survives the clear.
    always_comb begin
        pend_clr = '0;
        if (state == S_ALLOC) pend_clr[scan] = 1'b1;
        pend_nxt = (pend & ~pend_clr) | edge_set;
    end

    always_comb begin
        if (acc > SAT_HI)      mix_sat = 16'h7fff;
        else if (acc < SAT_LO) mix_sat = 16'h8000;
        else                   mix_sat = acc[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            scan       <= '0;
            vi         <= '0;
            trig_q     <= '0;
            pend       <= '0;
            active     <= '0;
            vbank      <= '0;
            vpos       <= '0;
            acc        <= '0;
            mix_out    <= '0;
            mix_valid  <= 1'b0;
            drop_count <= '0;
            overrun    <= 1'b0;
        end else begin
            trig_q    <= trig;
            pend      <= pend_nxt;
            mix_valid <= 1'b0;
            if (frame_tick && state != S_IDLE) overrun <= 1'b1;
            case (state)
                S_IDLE: if (frame_tick) begin
                    state <= S_ALLOC;
                    scan  <= '0;
                    acc   <= '0;
                end
                S_ALLOC: begin
                    if (pend[scan]) begin
                        if (hit) begin
                            vpos[hit_v] <= '0;
                        end else if (free) begin
                            active[free_v] <= 1'b1;
                            vbank[free_v]  <= scan;
                            vpos[free_v]   <= '0;
                        end else if (drop_count != 8'hff) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                    if (scan == 4'd15) begin
                        state <= S_FETCH;
                        vi    <= '0;
                    end else begin
                        scan <= scan + 4'd1;
                    end
                end
                S_FETCH: begin
                    if (active[vi])       state <= S_WAIT;
                    else if (vi == LAST_V) state <= S_OUT;
                    else                  vi    <= vi + 1'b1;
                end
                S_WAIT: if (rom_valid) begin
                    acc <= acc + rom_ext;
                    if (vpos[vi] == LAST_POS) active[vi] <= 1'b0;
                    else                      vpos[vi]   <= vpos[vi] + 1'b1;
                    if (vi == LAST_V) begin
                        state <= S_OUT;
                    end else begin
                        vi    <= vi + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_OUT: begin
                    mix_out   <= mix_sat;
                    mix_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_voice_scheduler.sv
// Scoreboard bench. Instance A: default POS_W=12. Instance B: POS_W=3 so the
// end-of-sample wrap is reachable. Expected mixes (with due cycle) and ROM
// addresses are queued when stimulus is driven and popped when the DUT emits.
module tb_sample_voice_scheduler;

    localparam int NV = 4;

    typedef struct {
        logic [15:0] mix;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] trig = '0, trig_b = '0;
    logic        frame_tick = 1'b0;

    logic        rom_req_a, rom_valid_a = 1'b0, mix_valid_a, ovr_a;
    logic [15:0] rom_addr_a, rom_data_a = '0, mix_out_a;
    logic [NV-1:0] va_a;
    logic [7:0]  drop_a;

    logic        rom_req_b, rom_valid_b = 1'b0, mix_valid_b, ovr_b;
    logic [6:0]  rom_addr_b;
    logic [15:0] rom_data_b = '0, mix_out_b;
    logic [NV-1:0] va_b;
    logic [7:0]  drop_b;

    int checks = 0, failures = 0;
    int cyc = 0;
    int lat = 1;
    logic [15:0] rom_tab [16];

    exp_t        q_mix_a[$], q_mix_b[$];
    logic [15:0] q_addr_a[$];
    logic [6:0]  q_addr_b[$];

    sample_voice_scheduler #(.NUM_VOICES(NV), .POS_W(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .trig(trig), .frame_tick(frame_tick),
        .rom_req(rom_req_a), .rom_addr(rom_addr_a), .rom_valid(rom_valid_a),
        .rom_data(rom_data_a), .mix_out(mix_out_a), .mix_valid(mix_valid_a),
        .voice_active(va_a), .drop_count(drop_a), .overrun(ovr_a));

    sample_voice_scheduler #(.NUM_VOICES(NV), .POS_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .trig(trig_b), .frame_tick(frame_tick),
        .rom_req(rom_req_b), .rom_addr(rom_addr_b), .rom_valid(rom_valid_b),
        .rom_data(rom_data_b), .mix_out(mix_out_b), .mix_valid(mix_valid_b),
        .voice_active(va_b), .drop_count(drop_b), .overrun(ovr_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ROM models: answer lat cycles after the request with rom_tab[bank].
    // Counters keep running through reset so a late response can be observed.
    int cnt_a = 0, cnt_b = 0;
    logic [3:0] bk_a, bk_b;
    always @(negedge clk) begin
        rom_valid_a = 1'b0;
        if (cnt_a > 0) begin
            cnt_a = cnt_a - 1;
            if (cnt_a == 0) begin rom_valid_a = 1'b1; rom_data_a = rom_tab[bk_a]; end
        end
        if (rom_req_a) begin cnt_a = lat; bk_a = rom_addr_a[15:12]; end
    end
    always @(negedge clk) begin
        rom_valid_b = 1'b0;
        if (cnt_b > 0) begin
            cnt_b = cnt_b - 1;
            if (cnt_b == 0) begin rom_valid_b = 1'b1; rom_data_b = rom_tab[bk_b]; end
        end
        if (rom_req_b) begin cnt_b = lat; bk_b = rom_addr_b[6:3]; end
    end

    // Monitors
    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev_a = 1'b0;
        else begin
            if (rom_req_a) begin
                if (prev_a) chk("req_b2b_a", 1, 0);
                if (q_addr_a.size() != 0) chk("addr_a", 32'(rom_addr_a), 32'(q_addr_a.pop_front()));
                else chk("spurious_req_a", 32'(rom_addr_a), 32'hffffffff);
            end
            prev_a = rom_req_a;
            if (mix_valid_a) begin
                if (q_mix_a.size() != 0) begin
                    e = q_mix_a.pop_front();
                    chk("mix_a", 32'(mix_out_a), 32'(e.mix));
                    chk("lat_a", 32'(cyc), 32'(e.cyc));
                end else chk("spurious_mix_a", 1, 0);
            end
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev_b = 1'b0;
        else begin
            if (rom_req_b) begin
                if (prev_b) chk("req_b2b_b", 1, 0);
                if (q_addr_b.size() != 0) chk("addr_b", 32'(rom_addr_b), 32'(q_addr_b.pop_front()));
                else chk("spurious_req_b", 32'(rom_addr_b), 32'hffffffff);
            end
            prev_b = rom_req_b;
            if (mix_valid_b) begin
                if (q_mix_b.size() != 0) begin
                    e = q_mix_b.pop_front();
                    chk("mix_b", 32'(mix_out_b), 32'(e.mix));
                    chk("lat_b", 32'(cyc), 32'(e.cyc));
                end else chk("spurious_mix_b", 1, 0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q_mix_a.size() + q_mix_b.size() + q_addr_a.size() + q_addr_b.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("frame_timeout", 32'(n < 300), 1);
        q_mix_a.delete(); q_mix_b.delete(); q_addr_a.delete(); q_addr_b.delete();
        @(posedge clk); #1;
    endtask

    // One frame: expected mix/active-voice count for each instance.
    task automatic do_frame(input logic [15:0] ma, input int ka, input logic [15:0] mb, input int kb);
        @(posedge clk); #1;
        q_mix_a.push_back('{ma, cyc + 16 + NV + ka * lat + 2});
        q_mix_b.push_back('{mb, cyc + 16 + NV + kb * lat + 2});
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        wait_idle();
    endtask

    task automatic pulse(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        trig = a; trig_b = b;
        @(posedge clk); #1;
        trig = '0; trig_b = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; trig = '0; trig_b = '0; frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_mix_out"},   32'(mix_out_a), 0);
        chk({tag, "_mix_valid"}, 32'(mix_valid_a), 0);
        chk({tag, "_rom_req"},   32'(rom_req_a), 0);
        chk({tag, "_rom_addr"},  32'(rom_addr_a), 0);
        chk({tag, "_active"},    32'(va_a), 0);
        chk({tag, "_drop"},      32'(drop_a), 0);
        chk({tag, "_overrun"},   32'(ovr_a), 0);
    endtask

    initial begin
        int t, n;
        foreach (rom_tab[i]) rom_tab[i] = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #2 chk_reset_outs("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle frame
        do_frame(16'h0000, 0, 16'h0000, 0);

        // Single voice, L = 1
        apply_reset();
        lat = 1; rom_tab[3] = 16'h1000;
        pulse(16'h0008, 16'h0);
        q_addr_a.push_back(16'h3000);
        do_frame(16'h1000, 1, 16'h0000, 0);
        chk("single_active", 32'(va_a), 32'b0001);
        q_addr_a.push_back(16'h3001);
        do_frame(16'h1000, 1, 16'h0000, 0);

        // Saturation, banks 0..3 on voices 0..3
        apply_reset();
        for (int i = 0; i < 4; i++) rom_tab[i] = 16'h7000;
        pulse(16'h000f, 16'h0);
        for (int i = 0; i < 4; i++) q_addr_a.push_back(16'(i << 12));
        do_frame(16'h7fff, 4, 16'h0000, 0);
        for (int i = 0; i < 4; i++) rom_tab[i] = 16'h9000;
        for (int i = 0; i < 4; i++) q_addr_a.push_back(16'((i << 12) | 1));
        do_frame(16'h8000, 4, 16'h0000, 0);
        rom_tab[0] = 16'h7000; rom_tab[1] = 16'h9000; rom_tab[2] = 16'h0010; rom_tab[3] = 16'h0000;
        for (int i = 0; i < 4; i++) q_addr_a.push_back(16'((i << 12) | 2));
        do_frame(16'h0010, 4, 16'h0000, 0);

        // Allocation overflow and retrigger
        apply_reset();
        foreach (rom_tab[i]) rom_tab[i] = '0;
        pulse(16'h001f, 16'h0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) q_addr_a.push_back(16'((i << 12) | f));
            do_frame(16'h0000, 4, 16'h0000, 0);
            if (f == 0) begin
                chk("ovf_drop", 32'(drop_a), 1);
                chk("ovf_active", 32'(va_a), 32'b1111);
            end
        end
        pulse(16'h0004, 16'h0);
        q_addr_a.push_back(16'h0003); q_addr_a.push_back(16'h1003);
        q_addr_a.push_back(16'h2000); q_addr_a.push_back(16'h3003);
        do_frame(16'h0000, 4, 16'h0000, 0);
        chk("retrig_drop", 32'(drop_a), 1);
        chk("retrig_active", 32'(va_a), 32'b1111);

        // End of sample on the POS_W=3 instance, bank 5
        apply_reset();
        rom_tab[5] = 16'h0100;
        pulse(16'h0, 16'h0020);
        for (int f = 0; f < 8; f++) begin
            q_addr_b.push_back(7'(8'h28 + f));
            do_frame(16'h0000, 0, 16'h0100, 1);
            if (f < 7) chk("eos_active_mid", 32'(va_b), 1);
        end
        chk("eos_active_end", 32'(va_b), 0);
        do_frame(16'h0000, 0, 16'h0000, 0);

        // Overrun with L = 20
        apply_reset();
        lat = 20; rom_tab[7] = 16'h0123;
        pulse(16'h0080, 16'h0);
        @(posedge clk); #1;
        t = cyc;
        q_mix_a.push_back('{16'h0123, t + 16 + NV + lat + 2});
        q_mix_b.push_back('{16'h0000, t + 16 + NV + 2});
        q_addr_a.push_back(16'h7000);
        frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (9) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        chk("overrun_set", 32'(ovr_a), 1);
        wait_idle();
        chk("overrun_sticky", 32'(ovr_a), 1);

        // Reset while waiting on the ROM; the response then lands after release
        @(posedge clk); #1;
        q_addr_a.push_back(16'h7001);
        frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        n = 0;
        while (q_addr_a.size() != 0 && n < 100) begin @(posedge clk); n++; end
        chk("wait_req_seen", 32'(q_addr_a.size()), 0);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset_outs("midrst");
        repeat (30) @(posedge clk);
        #1;
        chk("late_valid_mix", 32'(mix_out_a), 0);
        chk("late_valid_active", 32'(va_a), 0);
        lat = 1;
        do_frame(16'h0000, 0, 16'h0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
